pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024, the number of consecutive synchronized-locked cycles required before the system reset is released.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65536, the number of cycles to wait for lock before requesting a PLL reset.
REQ-003 SHALL have parameter PLL_RST_CYCLES, default 8, the width in cycles of the PLL reset pulse.
REQ-004 SHALL have port clk  input  1  free-running reference clock (PLL input clock, not a PLL output).
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port locked  input  1  PLL LOCK, asynchronous to clk.
REQ-007 SHALL have port lol_clr  input  1  synchronous clear of lol_count.
REQ-008 SHALL have port pll_rst  output  1  active-high reset request to the PLL RST pin.
REQ-009 SHALL have port sys_rstn  output  1  active-low system reset for logic clocked by PLL outputs.
REQ-010 SHALL have port ready  output  1  high while the PLL is considered stable.
REQ-011 SHALL have port lol_count  output  8  saturating loss-of-lock event count.

Function
REQ-012 SHALL synchronize locked through exactly 2 flip-flops into locked_s, with no other use of the raw input.
REQ-013 SHALL implement the states WAIT_LOCK, STABLE, RUN and PLL_RST with a single cycle counter of at least 17 bits.
REQ-014 SHALL, in WAIT_LOCK, enter STABLE with the counter at 0 when locked_s=1, else enter PLL_RST when the counter reaches TIMEOUT_CYCLES-1, else increment the counter.
REQ-015 SHALL, in STABLE, return to WAIT_LOCK with the counter at 0 and lol_count unchanged when locked_s=0, else enter RUN when the counter reaches STABLE_CYCLES-1, else increment the counter.
REQ-016 SHALL, in RUN, stay while locked_s=1; on locked_s=0 it SHALL enter WAIT_LOCK with the counter at 0 and increment lol_count (saturating at 255).
REQ-017 SHALL, in PLL_RST, enter WAIT_LOCK with the counter at 0 after exactly PLL_RST_CYCLES cycles, ignoring locked_s.
REQ-018 SHALL drive all outputs from flip-flops, with values equal to a decode of the current state: sys_rstn=1 and ready=1 only in RUN, pll_rst=1 only in PLL_RST.
REQ-019 SHALL therefore keep STABLE exactly STABLE_CYCLES cycles long when lock holds, and release sys_rstn 2+1+STABLE_CYCLES cycles after locked rises (2 sync, 1 WAIT_LOCK->STABLE).
REQ-020 SHALL assert sys_rstn=0 and ready=0 on the first clk edge after locked_s falls in RUN.
REQ-021 SHALL clear lol_count to 0 on lol_clr=1; if lol_clr and a RUN loss-of-lock coincide, the result SHALL be 1.
REQ-022 SHALL leave lol_count at 255 on further loss-of-lock events once it is saturated.
REQ-023 SHALL restart the timeout from 0 on every entry to WAIT_LOCK, repeating PLL_RST pulses indefinitely while the PLL fails to lock.

Reset
REQ-024 SHALL, while rstn=0, asynchronously force WAIT_LOCK, counter=0, both sync flops=0, lol_count=0, pll_rst=0, sys_rstn=0 and ready=0.
REQ-025 SHALL, on rstn deassertion mid-operation (any state), resume from WAIT_LOCK with no carried-over count or pulse.

Verification
REQ-026 SHALL cover: locked=1 from reset release, STABLE_CYCLES=16 -> sys_rstn and ready rise exactly 19 cycles after release, and pll_rst stays 0.
REQ-027 SHALL cover: locked=0 forever, TIMEOUT_CYCLES=32, PLL_RST_CYCLES=8 -> pll_rst high for 8 cycles, starting each 40 cycles, repeated.
REQ-028 SHALL cover: locked drop for 3 cycles during STABLE -> no RUN entry, lol_count=0, then a full STABLE_CYCLES re-count after recovery.
REQ-029 SHALL cover: 260 loss-of-lock events in RUN -> lol_count=255; lol_clr coincident with event 261 -> lol_count=1.
REQ-030 SHALL cover: rstn pulsed low in RUN -> sys_rstn=0 immediately (asynchronously), lol_count=0, and normal re-lock sequence afterward.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronizes LOCK, waits for a stable lock before releasing the
// system reset, pulses the PLL reset on lock timeout and counts loss-of-lock events.
module pll_lock_supervisor #(
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned PLL_RST_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       locked,
    input  logic       lol_clr,
    output logic       pll_rst,
    output logic       sys_rstn,
    output logic       ready,
    output logic [7:0] lol_count
);

    localparam int unsigned MaxA   = (STABLE_CYCLES > TIMEOUT_CYCLES) ? STABLE_CYCLES
                                                                      : TIMEOUT_CYCLES;
    localparam int unsigned MaxCyc = (MaxA > PLL_RST_CYCLES) ? MaxA : PLL_RST_CYCLES;
    localparam int unsigned CntW   = ($clog2(MaxCyc) > 17) ? $clog2(MaxCyc) : 17;

    typedef enum logic [1:0] {
        StWaitLock,
        StStable,
        StRun,
        StPllRst
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        sync_q, sync_d;
    logic [7:0]        lol_q, lol_d;
    logic              pll_rst_q, pll_rst_d;
    logic              sys_rstn_q, sys_rstn_d;
    logic              ready_q, ready_d;
    logic              locked_s;
    logic              lol_evt;

    assign locked_s = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], locked};
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        lol_evt = 1'b0;

        unique case (state_q)
            StWaitLock: begin
                if (locked_s) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StPllRst;
                    cnt_d   = '0;
                end
            end
            StStable: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(STABLE_CYCLES - 1)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = StWaitLock;
                    lol_evt = 1'b1;
                end
            end
            StPllRst: begin
                // LOCK is meaningless while the PLL is held in reset
                if (cnt_q == CntW'(PLL_RST_CYCLES - 1)) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StWaitLock;
                cnt_d   = '0;
            end
        endcase

        lol_d = lol_q;
        if (lol_clr) begin
            lol_d = {7'b0, lol_evt};
        end else if (lol_evt && (lol_q != 8'hff)) begin
            lol_d = lol_q + 8'd1;
        end

        // Registered decode of the next state keeps outputs aligned with state_q
        pll_rst_d  = (state_d == StPllRst);
        sys_rstn_d = (state_d == StRun);
        ready_d    = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StWaitLock;
            cnt_q      <= '0;
            sync_q     <= 2'b00;
            lol_q      <= 8'd0;
            pll_rst_q  <= 1'b0;
            sys_rstn_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_q     <= sync_d;
            lol_q      <= lol_d;
            pll_rst_q  <= pll_rst_d;
            sys_rstn_q <= sys_rstn_d;
            ready_q    <= ready_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rstn  = sys_rstn_q;
    assign ready     = ready_q;
    assign lol_count = lol_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed and randomized bench for pll_lock_supervisor against a timer-based reference model.
module tb_pll_lock_supervisor;

    localparam int STABLE  = 16;
    localparam int TIMEOUT = 32;
    localparam int PRST    = 8;

    logic       clk = 1'b0;
    logic       rstn;
    logic       locked;
    logic       lol_clr;
    logic       pll_rst;
    logic       sys_rstn;
    logic       ready;
    logic [7:0] lol_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: sync pipeline plus independent timers
    int m_s1, m_s2, m_wait, m_settle, m_pulse, m_lol;
    bit m_run;

    pll_lock_supervisor #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .PLL_RST_CYCLES(PRST)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .locked   (locked),
        .lol_clr  (lol_clr),
        .pll_rst  (pll_rst),
        .sys_rstn (sys_rstn),
        .ready    (ready),
        .lol_count(lol_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1     = 0;
        m_s2     = 0;
        m_wait   = 0;
        m_settle = -1;
        m_pulse  = 0;
        m_lol    = 0;
        m_run    = 1'b0;
    endtask

    task automatic model_step();
        int ls;
        bit evt;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = int'(locked);
        evt  = 1'b0;
        if (m_pulse > 0) begin
            m_pulse--;
            if (m_pulse == 0) m_wait = 0;
        end else if (m_run) begin
            if (ls == 0) begin
                m_run  = 1'b0;
                m_wait = 0;
                evt    = 1'b1;
            end
        end else if (m_settle >= 0) begin
            if (ls == 0) begin
                m_settle = -1;
                m_wait   = 0;
            end else if (m_settle == STABLE - 1) begin
                m_settle = -1;
                m_run    = 1'b1;
            end else begin
                m_settle++;
            end
        end else if (ls != 0) begin
            m_settle = 0;
        end else if (m_wait == TIMEOUT - 1) begin
            m_pulse = PRST;
        end else begin
            m_wait++;
        end
        if (lol_clr) m_lol = evt ? 1 : 0;
        else if (evt && m_lol < 255) m_lol++;
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later, return at negedge
    task automatic cyc();
        @(posedge clk);
        if (!rstn) model_reset();
        else model_step();
        #1;
        chk("pll_rst", 32'(pll_rst), 32'(m_pulse > 0));
        chk("sys_rstn", 32'(sys_rstn), 32'(m_run));
        chk("ready", 32'(ready), 32'(m_run));
        chk("lol_count", 32'(lol_count), 32'(m_lol));
        @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 300) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_not_ready(output int n);
        n = 0;
        while (ready && n < 300) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n, h, l;
        bit seen_rst;

        rstn    = 1'b0;
        locked  = 1'b1;
        lol_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_pll_rst", 32'(pll_rst), 32'd0);
        chk("reset_sys_rstn", 32'(sys_rstn), 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_lol_count", 32'(lol_count), 32'd0);

        // Locked from reset release: ready after 2 sync + 1 + STABLE cycles
        rstn     = 1'b1;
        n        = 0;
        seen_rst = 1'b0;
        while (!sys_rstn && n < 300) begin
            cyc();
            n++;
            if (pll_rst) seen_rst = 1'b1;
        end
        chk("release_to_sys_rstn", 32'(n), 32'd19);
        chk("release_ready", 32'(ready), 32'd1);
        chk("release_no_pll_rst", 32'(seen_rst), 32'd0);

        // Loss of lock in RUN
        locked = 1'b0;
        n      = 0;
        while (sys_rstn && n < 50) begin
            cyc();
            n++;
        end
        chk("lol_fall_latency", 32'(n), 32'd3);
        chk("lol_count_first", 32'(lol_count), 32'd1);

        // Lock never returns: periodic PLL reset pulses
        n = 0;
        while (!pll_rst && n < 200) begin
            cyc();
            n++;
        end
        chk("timeout_to_pll_rst", 32'(n), 32'd32);
        for (int p = 0; p < 2; p++) begin
            h = 0;
            while (pll_rst && h < 50) begin
                cyc();
                h++;
            end
            chk("pll_rst_width", 32'(h), 32'd8);
            l = 0;
            while (!pll_rst && l < 200) begin
                cyc();
                l++;
            end
            chk("pll_rst_gap", 32'(l), 32'd32);
        end
        h = 0;
        while (pll_rst && h < 50) begin
            cyc();
            h++;
        end

        // Short glitch during STABLE forces a full re-count
        locked = 1'b1;
        repeat (8) cyc();
        chk("stable_no_ready", 32'(ready), 32'd0);
        locked = 1'b0;
        repeat (3) cyc();
        locked = 1'b1;
        wait_ready(n);
        chk("stable_recount", 32'(n), 32'd19);
        chk("stable_drop_lol", 32'(lol_count), 32'd1);

        // Clear, then saturate the event counter
        lol_clr = 1'b1;
        cyc();
        lol_clr = 1'b0;
        chk("lol_clr_zero", 32'(lol_count), 32'd0);
        for (int e = 0; e < 260; e++) begin
            locked = 1'b0;
            wait_not_ready(n);
            locked = 1'b1;
            wait_ready(n);
        end
        chk("lol_saturate", 32'(lol_count), 32'd255);
        locked = 1'b0;
        cyc();
        cyc();
        lol_clr = 1'b1;
        cyc();
        lol_clr = 1'b0;
        chk("lol_clr_with_event_ready", 32'(ready), 32'd0);
        chk("lol_clr_with_event", 32'(lol_count), 32'd1);

        // Randomized lock behaviour with sporadic clears
        for (int s = 0; s < 60; s++) begin
            locked = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 60)) begin
                lol_clr = ($urandom_range(0, 15) == 0);
                cyc();
            end
        end
        lol_clr = 1'b0;

        // Asynchronous reset while running
        locked = 1'b1;
        wait_ready(n);
        chk("run_before_reset", 32'(ready), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_sys_rstn", 32'(sys_rstn), 32'd0);
        chk("async_ready", 32'(ready), 32'd0);
        chk("async_lol_count", 32'(lol_count), 32'd0);
        chk("async_pll_rst", 32'(pll_rst), 32'd0);
        model_reset();
        cyc();
        cyc();
        rstn = 1'b1;
        wait_ready(n);
        chk("relock_after_reset", 32'(n), 32'd19);
        chk("relock_lol_count", 32'(lol_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
